// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller_pkg
// Description : Shared definitions for the interrupt controller. It holds the
//               FSM state encoding, the cause encoding, the default handler
//               vectors and the scheduler timer width.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_TIMER = 2'b01;
  localparam logic [1:0] CAUSE_KEY   = 2'b10;

  localparam logic [17:0] DEFAULT_SCHED_VEC = 18'd9636;
  localparam logic [17:0] DEFAULT_KEY_VEC   = 18'd9700;

  // The counter is wide enough for periods up to 2^24 cycles.
  localparam int TIMER_W = 24;

endpackage
`default_nettype wire

// File: rtl/sched_timer.sv
`default_nettype none
// ============================================================================
// Module      : sched_timer
// Description : Free-running reload down-counter. It loads PERIOD-1, counts
//               down once per cycle and raises a one-cycle expiry pulse while
//               the count is zero. It reloads on that same cycle.
// Ports       : clock  - system clock
//               reset  - async active-high reset (count reloads)
//               expiry - one-cycle pulse, once every PERIOD cycles
// Revision    : 1.0 - initial release
// ============================================================================
module sched_timer
  import interrupt_controller_pkg::*;
#(
  parameter int PERIOD = 262144
) (
  input  logic clock,
  input  logic reset,
  output logic expiry
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(PERIOD - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= RELOAD;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expiry = (count == '0);

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Two-source (scheduler timer, keyboard) interrupt controller
//               using an IDLE/REQ/SERVICE handshake with the control unit. A
//               taken request latches its winner, and the timer beats the
//               keyboard. The interrupt controller does not nest requests.
//               Events that arrive while a request is in progress only set
//               pending flags.
// Config      : ICTRL_KEY_IRQ_EN - when defined, the keyboard source is
//               built. When undefined, key_sample is ignored and pending[1]
//               stays 0.
// Ports       : clock, reset   - clock, async active-high reset
//               irq_enable     - global enable, gates IDLE -> REQ only
//               key_sample     - keyboard toggle flag (asynchronous)
//               ack / eoi      - vector taken / handler finished
//               interrupt      - request to control unit (state REQ)
//               vector[17:0]   - latched handler address
//               cause[1:0]     - latched source, 00 while idle
//               pending[1:0]   - {key, timer} pending flags
//               in_service     - handler active (state SERVICE)
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          TIMER_PERIOD = 262144,
  parameter logic [17:0] SCHED_VEC    = DEFAULT_SCHED_VEC,
  parameter logic [17:0] KEY_VEC      = DEFAULT_KEY_VEC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        irq_enable,
  input  logic        key_sample,
  input  logic        ack,
  input  logic        eoi,
  output logic        interrupt,
  output logic [17:0] vector,
  output logic [1:0]  cause,
  output logic [1:0]  pending,
  output logic        in_service
);

  state_t      state, state_next;
  logic        timer_exp;
  logic        key_event;
  logic [1:0]  pend_q, pend_next, pend_clr;
  logic        src_key_q;      // latched winner: 0 timer, 1 key
  logic [17:0] vec_q;
  logic        take, accept;

  sched_timer #(
    .PERIOD (TIMER_PERIOD)
  ) u_sched_timer (
    .clock  (clock),
    .reset  (reset),
    .expiry (timer_exp)
  );

`ifdef ICTRL_KEY_IRQ_EN
  logic       sync1, sync2, key_prev;
  logic [1:0] settle;

  // The edge detector stays muted until the synchronizer holds only
  // post-reset samples. A key_sample that is high at release therefore
  // does not count as an event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      key_prev <= 1'b0;
      settle   <= 2'd0;
    end else begin
      sync1    <= key_sample;
      sync2    <= sync1;
      key_prev <= sync2;
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end
    end
  end

  assign key_event = (settle == 2'd3) && (sync2 ^ key_prev);
`else
  logic unused_key_sample;
  assign unused_key_sample = key_sample;
  assign key_event         = 1'b0;
`endif

  always_comb begin
    state_next = state;
    take       = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (irq_enable && (pend_q != 2'b00)) begin
          state_next = ST_REQ;
          take       = 1'b1;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_next = ST_SERVICE;
          accept     = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The accepted source clears its flag. An event of the same source in
  // that same cycle re-sets the flag, because the set term is ORed in last.
  assign pend_clr  = accept ? (src_key_q ? 2'b10 : 2'b01) : 2'b00;
  assign pend_next = {key_event, timer_exp} | (pend_q & ~pend_clr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pend_q    <= 2'b00;
      src_key_q <= 1'b0;
      vec_q     <= SCHED_VEC;
    end else begin
      state  <= state_next;
      pend_q <= pend_next;
      if (take) begin
        // The key source wins only when the timer flag is clear.
        src_key_q <= ~pend_q[0];
        vec_q     <= pend_q[0] ? SCHED_VEC : KEY_VEC;
      end
    end
  end

  assign interrupt  = (state == ST_REQ);
  assign in_service = (state == ST_SERVICE);
  assign pending    = pend_q;
  assign vector     = vec_q;
  assign cause      = (state == ST_IDLE) ? CAUSE_NONE
                    : (src_key_q ? CAUSE_KEY : CAUSE_TIMER);

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed testbench for interrupt_controller with
//               TIMER_PERIOD=8. Cycle n is the interval after the n-th
//               rising edge following reset release. Outputs are sampled on
//               falling edges, and inputs are driven there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

`ifdef ICTRL_KEY_IRQ_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        irq_enable;
  logic        key_sample;
  logic        ack;
  logic        eoi;
  logic        interrupt;
  logic [17:0] vector;
  logic [1:0]  cause;
  logic [1:0]  pending;
  logic        in_service;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  interrupt_controller #(
    .TIMER_PERIOD (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_enable (irq_enable),
    .key_sample (key_sample),
    .ack        (ack),
    .eoi        (eoi),
    .interrupt  (interrupt),
    .vector     (vector),
    .cause      (cause),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    irq_enable = 1'b1;
    key_sample = 1'b1;
    ack        = 1'b0;
    eoi        = 1'b0;
    #1;
    check("rst_interrupt",  32'(interrupt),  0);
    check("rst_in_service", 32'(in_service), 0);
    check("rst_pending",    32'(pending),    0);
    check("rst_cause",      32'(cause),      0);
    check("rst_vector",     32'(vector),     9636);

    repeat (2) @(negedge clock);
    reset = 1'b0;
    cyc   = 0;

    // The first expiry occurs in cycle 7. Pending shows in cycle 8, and the
    // request shows in cycle 9.
    goto(7);  check("pend_before_expiry", 32'(pending), 0);
    goto(8);  check("pend_after_expiry",  32'(pending), 1);
              check("irq_not_yet",        32'(interrupt), 0);
    goto(9);  check("irq_first",          32'(interrupt), 1);
              check("cause_first",        32'(cause), 1);
              check("vector_first",       32'(vector), 9636);
    goto(14); check("irq_held",           32'(interrupt), 1);
              check("no_service_yet",     32'(in_service), 0);

    // The ack lands in the same cycle as the next expiry (cycle 15), so the
    // timer flag survives.
    goto(15); ack = 1'b1;
    goto(16); ack = 1'b0;
              check("svc_entered",        32'(in_service), 1);
              check("irq_dropped",        32'(interrupt), 0);
              check("pend_kept_on_ack",   32'(pending), 1);
              check("cause_in_service",   32'(cause), 1);
    goto(20); eoi = 1'b1;
    goto(21); eoi = 1'b0;
              check("idle_after_eoi",     32'(in_service), 0);
              check("idle_no_irq",        32'(interrupt), 0);
              check("idle_cause",         32'(cause), 0);
              check("idle_vector_held",   32'(vector), 9636);
    goto(22); check("reirq_after_eoi",    32'(interrupt), 1);
              check("reirq_cause",        32'(cause), 1);
              eoi = 1'b1;                 // eoi while in REQ is ignored
    goto(23); eoi = 1'b0;
              check("eoi_in_req_ignored", 32'(interrupt), 1);
    goto(24); ack = 1'b1;
    goto(25); ack = 1'b0;
              check("svc_second",         32'(in_service), 1);
              check("pend_cleared",       32'(pending), 0);
              ack = 1'b1;                 // ack while in SERVICE is ignored
    goto(26); ack = 1'b0;
              check("ack_in_svc_ignored", 32'(in_service), 1);
              irq_enable = 1'b0;
    goto(27); eoi = 1'b1;
    goto(28); eoi = 1'b0;
              check("idle_disabled",      32'(in_service), 0);

    // With the enable low for 40 cycles, expiries coalesce into a single
    // pending bit, and key toggles have no effect when the key source is
    // absent.
    for (int c = 28; c < 68; c++) begin
      goto(c);
      check("irq_masked",   32'(interrupt), 0);
      check("pend_masked",  32'(pending), (c >= 32) ? 1 : 0);
      if (!KEY_EN && (c % 5 == 0) && c <= 50) key_sample = ~key_sample;
    end
    irq_enable = 1'b1;
    goto(68); check("single_req",         32'(interrupt), 1);
              check("single_req_cause",   32'(cause), 1);
              ack = 1'b1;
    goto(69); ack = 1'b0;
              check("single_svc_pend",    32'(pending), 0);
              eoi = 1'b1;
    goto(70); eoi = 1'b0;
              check("no_second_req_a",    32'(interrupt), 0);
              check("no_second_pend",     32'(pending), 0);
    goto(71); check("no_second_req_b",    32'(interrupt), 0);
    goto(72); check("pend_after_71",      32'(pending), 1);
    goto(73); check("req_again",          32'(interrupt), 1);
              irq_enable = 1'b0;          // must not withdraw the request
    goto(75); check("req_not_withdrawn",  32'(interrupt), 1);
              ack = 1'b1;
    goto(76); ack = 1'b0;
              check("svc_before_reset",   32'(in_service), 1);
              irq_enable = 1'b1;

    // Asynchronous reset in the middle of SERVICE.
    #2 reset = 1'b1;
    #1;
    check("midrst_interrupt",  32'(interrupt),  0);
    check("midrst_in_service", 32'(in_service), 0);
    check("midrst_pending",    32'(pending),    0);
    check("midrst_cause",      32'(cause),      0);
    check("midrst_vector",     32'(vector),     9636);
    @(negedge clock);
    reset = 1'b0;
    cyc   = 0;

    goto(7);  check("rst2_pend_before",   32'(pending), 0);
              key_sample = ~key_sample;   // key toggle together with timer expiry
    goto(8);  check("rst2_pend_timer",    32'(pending), 1);
    goto(9);  check("rst2_irq",           32'(interrupt), 1);
              check("rst2_cause_timer",   32'(cause), 1);
              check("rst2_vector_timer",  32'(vector), 9636);
    goto(10); check("both_pending",       32'(pending), KEY_EN ? 3 : 1);
              ack = 1'b1;
    goto(11); ack = 1'b0;
              check("svc_timer",          32'(in_service), 1);
              check("key_left_pending",   32'(pending), KEY_EN ? 2 : 0);
              eoi = 1'b1;
    goto(12); eoi = 1'b0;
              check("idle_between",       32'(in_service), 0);
    goto(13); check("key_irq",            32'(interrupt), KEY_EN ? 1 : 0);
              check("key_cause",          32'(cause), KEY_EN ? 2 : 0);
              check("key_vector",         32'(vector), KEY_EN ? 9700 : 9636);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
